// File: rtl/hilo_div_unit.sv
// HI/LO register owner with a multi-cycle signed radix-2 restoring divider.
// Raises a decode stall for any HI/LO access or a new div while a division is in flight.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             read_hi,
  input  logic             read_lo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;

  // One extra bit of headroom: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    diff;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};

  assign busy  = (state_q != StIdle);
  assign stall = busy & (start | read_hi | read_lo | wr_hi | wr_lo);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero completes at once and overrides a same-cycle mthi.
            hi_d  = dividend;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dsr_d   = divisor[WIDTH-1] ? -divisor : divisor;
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StFix: begin
        lo_d    = q_neg_q ? -quo_q : quo_q;
        hi_d    = r_neg_q ? -rem_q : rem_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

`ifndef SYNTHESIS
  always @(negedge clock) begin
    if (dbz_q) $display("hilo_div_unit: divide by zero, hi=%h lo=%h", hi_q, lo_q);
  end
`endif

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed scenarios plus randomized divides
// compared against a plain-arithmetic signed divide model.
module tb_hilo_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        read_hi;
  logic        read_lo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int checks = 0;
  int errors = 0;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .read_hi (read_hi),
    .read_lo (read_lo),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // MIPS div semantics: truncate toward zero, remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eq, er, hi0, lo0;
    int cyc, exp_cyc;
    bit held;
    model(a, b, eq, er);
    exp_cyc = (b == 32'd0) ? 0 : 33;
    @(negedge clock);
    dividend = a; divisor = b; start = 1'b1;
    hi0 = hi; lo0 = lo;
    @(posedge clock); #1;
    start = 1'b0;
    held = 1'b1;
    cyc  = 0;
    while (busy && cyc < 40) begin
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (lo !== eq) begin
      errors++;
      $display("FAIL %s lo (%h/%h): got %h expected %h", name, a, b, lo, eq);
    end
    checks++;
    if (hi !== er) begin
      errors++;
      $display("FAIL %s hi (%h/%h): got %h expected %h", name, a, b, hi, er);
    end
    if (b != 32'd0) begin
      checks++;
      if (held !== 1'b1) begin
        errors++;
        $display("FAIL %s hold_during_run: got %0d expected 1", name, held);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    read_hi = 1'b0; read_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    #23;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_div(32'd100, 32'd7, "div_100_7");
  endtask

  task automatic test_signs();
    run_div(-32'sd100, 32'd7, "div_m100_7");
    run_div(32'd100, -32'sd7, "div_100_m7");
  endtask

  task automatic test_wrap_dbz();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
    run_div(32'd5, 32'd0, "div_by_zero");
  endtask

  task automatic test_hazard();
    int sc, cyc;
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    // Decode keeps mflo and a second div pending under stall.
    read_lo = 1'b1; dividend = 32'd7; divisor = 32'd2;
    sc = 0;
    while (sc < 40) begin
      @(negedge clock);
      if (!stall) break;
      sc++;
    end
    checks++;
    if (sc !== 33) begin errors++; $display("FAIL hazard_stall_cycles: got %0d expected 33", sc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hazard_busy_after: got %b expected 0", busy); end
    checks++;
    if (lo !== 32'd333) begin errors++; $display("FAIL hazard_lo: got %0d expected 333", lo); end
    checks++;
    if (hi !== 32'd1) begin errors++; $display("FAIL hazard_hi: got %0d expected 1", hi); end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL hazard_second_accept: got %b expected 1", busy); end
    start = 1'b0; read_lo = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL hazard_second_cycles: got %0d expected 33", cyc); end
    checks++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      errors++;
      $display("FAIL hazard_second_result: got lo=%0d hi=%0d expected lo=3 hi=1", lo, hi);
    end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    @(negedge clock);
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    @(posedge clock); #1;
    checks++;
    if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi: got %h expected deadbeef", hi); end
    wr_hi = 1'b0;
    // Divide-by-zero result wins over a same-cycle mthi.
    @(negedge clock);
    wr_hi = 1'b1; wr_data = 32'h0000_1234; start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    @(posedge clock); #1;
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_dbz_priority: got hi=%h lo=%h busy=%b expected hi=5 lo=ffffffff busy=0",
               hi, lo, busy);
    end
    wr_hi = 1'b0; start = 1'b0;
    @(negedge clock);
    start = 1'b1; dividend = 32'd50; divisor = 32'd6;
    @(posedge clock); #1;
    start = 1'b0; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(negedge clock);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mtlo_run_stall: got %b expected 1", stall); end
    cyc = 0;
    while (busy && cyc < 40) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (lo !== 32'd8 || hi !== 32'd2) begin
      errors++;
      $display("FAIL mtlo_ignored: got lo=%h hi=%h expected lo=8 hi=2", lo, hi);
    end
    @(posedge clock); #1;
    checks++;
    if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_retry: got %h expected cafef00d", lo); end
    wr_lo = 1'b0;
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    run_div(32'd9, 32'd2, "div_after_abort");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      unique case (i % 6)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        4: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_wrap_dbz();
    test_hazard();
    test_mthi_mtlo();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
